// File: rtl/common_params.sv
// common_params: shared datapath width, register index width, ALU op encoding and bubble op
package common_params;
  localparam int BITS = 32;
  localparam int REG_IDX_W = 5;
  typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND} alu_t;
  localparam alu_t BUBBLE_ALU_OP = ADD;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID/EX bundle; master drives decode/stall/flush/MEM/WB, slave drives ALU operands and EX control
interface id_ex_stage_if;
  import common_params::*;
  logic STALL, FLUSH, ID_VALID, ID_USES_RS1, ID_USES_RS2, ID_USE_IMM, ID_USE_PC, ID_RD_WE, ID_MEM_RD;
  logic [BITS-1:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [REG_IDX_W-1:0] ID_RS1, ID_RS2, ID_RD;
  alu_t ID_ALU_OP;
  logic [REG_IDX_W-1:0] MEM_RD, WB_RD;
  logic MEM_RD_WE, WB_RD_WE;
  logic [BITS-1:0] MEM_FWD_DATA, WB_DATA;
  logic LOAD_USE_STALL, EX_VALID, EX_RD_WE, EX_MEM_RD;
  logic [BITS-1:0] A_in, B_in, EX_PC, EX_STORE_DATA;
  logic [4:0] SHAMT;
  alu_t ALU_OP;
  logic [REG_IDX_W-1:0] EX_RD;
  modport master (
    output STALL, FLUSH, ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_RS1, ID_RS2, ID_RD,
           ID_USES_RS1, ID_USES_RS2, ID_IMM, ID_USE_IMM, ID_USE_PC, ID_ALU_OP, ID_RD_WE, ID_MEM_RD,
           MEM_RD, MEM_RD_WE, MEM_FWD_DATA, WB_RD, WB_RD_WE, WB_DATA,
    input  LOAD_USE_STALL, A_in, B_in, SHAMT, ALU_OP, EX_VALID, EX_RD_WE, EX_MEM_RD, EX_RD, EX_PC, EX_STORE_DATA
  );
  modport slave (
    input  STALL, FLUSH, ID_VALID, ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_RS1, ID_RS2, ID_RD,
           ID_USES_RS1, ID_USES_RS2, ID_IMM, ID_USE_IMM, ID_USE_PC, ID_ALU_OP, ID_RD_WE, ID_MEM_RD,
           MEM_RD, MEM_RD_WE, MEM_FWD_DATA, WB_RD, WB_RD_WE, WB_DATA,
    output LOAD_USE_STALL, A_in, B_in, SHAMT, ALU_OP, EX_VALID, EX_RD_WE, EX_MEM_RD, EX_RD, EX_PC, EX_STORE_DATA
  );
endinterface

// File: rtl/fwd_mux.sv
// fwd_mux: operand select (x0 -> 0, then MEM, then WB, then registered data); idx/reg_data in, val out
module fwd_mux
  import common_params::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [BITS-1:0]      reg_data,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic                 mem_rd_we,
  input  logic [BITS-1:0]      mem_data,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 wb_rd_we,
  input  logic [BITS-1:0]      wb_data,
  output logic [BITS-1:0]      val
);
  assign val = idx == '0 ? '0 :
               (mem_rd_we && mem_rd == idx) ? mem_data :
               (wb_rd_we && wb_rd == idx) ? wb_data : reg_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with load-use bubbles, stall/flush and MEM/WB forwarding; clk/rst plus id_ex_stage_if slave bus
module id_ex_stage
  import common_params::*;
(
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  logic valid_q, rd_we_q, mem_rd_q, use_imm_q, use_pc_q;
  logic [REG_IDX_W-1:0] rs1_q, rs2_q, rd_q;
  logic [BITS-1:0] pc_q, imm_q, rs1_d, rs2_d, rs1f, rs2f;
  alu_t op_q;
  logic lus, wb_ok;
  assign wb_ok = bus.WB_RD_WE && bus.WB_RD != '0;
  assign lus = bus.ID_VALID && valid_q && mem_rd_q && rd_q != '0 &&
               ((bus.ID_USES_RS1 && bus.ID_RS1 == rd_q) || (bus.ID_USES_RS2 && bus.ID_RS2 == rd_q));
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rd_we_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      use_imm_q <= 1'b0;
      use_pc_q  <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      rs1_d     <= '0;
      rs2_d     <= '0;
      op_q      <= BUBBLE_ALU_OP;
    end else if (bus.FLUSH || (!bus.STALL && (lus || !bus.ID_VALID))) begin
      valid_q  <= 1'b0;
      rd_we_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      rd_q     <= '0;
      op_q     <= BUBBLE_ALU_OP;
    end else if (bus.STALL) begin
      rs1_d <= (wb_ok && bus.WB_RD == rs1_q) ? bus.WB_DATA : rs1_d;
      rs2_d <= (wb_ok && bus.WB_RD == rs2_q) ? bus.WB_DATA : rs2_d;
    end else begin
      valid_q   <= 1'b1;
      rd_we_q   <= bus.ID_RD_WE;
      mem_rd_q  <= bus.ID_MEM_RD;
      use_imm_q <= bus.ID_USE_IMM;
      use_pc_q  <= bus.ID_USE_PC;
      rs1_q     <= bus.ID_RS1;
      rs2_q     <= bus.ID_RS2;
      rd_q      <= bus.ID_RD;
      pc_q      <= bus.ID_PC;
      imm_q     <= bus.ID_IMM;
      op_q      <= bus.ID_ALU_OP;
      rs1_d     <= (wb_ok && bus.WB_RD == bus.ID_RS1) ? bus.WB_DATA : bus.ID_RS1_DATA;
      rs2_d     <= (wb_ok && bus.WB_RD == bus.ID_RS2) ? bus.WB_DATA : bus.ID_RS2_DATA;
    end
  end
  fwd_mux u_fwd1 (.idx(rs1_q), .reg_data(rs1_d), .mem_rd(bus.MEM_RD), .mem_rd_we(bus.MEM_RD_WE),
                  .mem_data(bus.MEM_FWD_DATA), .wb_rd(bus.WB_RD), .wb_rd_we(bus.WB_RD_WE),
                  .wb_data(bus.WB_DATA), .val(rs1f));
  fwd_mux u_fwd2 (.idx(rs2_q), .reg_data(rs2_d), .mem_rd(bus.MEM_RD), .mem_rd_we(bus.MEM_RD_WE),
                  .mem_data(bus.MEM_FWD_DATA), .wb_rd(bus.WB_RD), .wb_rd_we(bus.WB_RD_WE),
                  .wb_data(bus.WB_DATA), .val(rs2f));
  assign bus.LOAD_USE_STALL = lus;
  assign bus.A_in = use_pc_q ? pc_q : rs1f;
  assign bus.B_in = use_imm_q ? imm_q : rs2f;
  assign bus.SHAMT = bus.B_in[4:0];
  assign bus.ALU_OP = op_q;
  assign bus.EX_VALID = valid_q;
  assign bus.EX_RD_WE = rd_we_q;
  assign bus.EX_MEM_RD = mem_rd_q;
  assign bus.EX_RD = rd_q;
  assign bus.EX_PC = pc_q;
  assign bus.EX_STORE_DATA = rs2f;
endmodule
